// File: rtl/seg_scan.sv
// seg_scan: four-digit time-multiplexed scanner feeding a single 7-segment decoder.
// Holds a double-buffered 16-bit display value and walks digits 0..3. Each digit slot
// opens with an all-off guard interval. Optional leading-zero blanking is enabled by
// defining SEG_SCAN_BLANK_EN.
module seg_scan #(
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned GUARD    = 2000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] value,
   output logic [3:0]  nibble,
   output logic [3:0]  digit_sel,
   output logic        frame_done,
   output logic        pend
);

   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] GUARD_V = DIV_W'(GUARD);

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_idx;
   logic [15:0]      r_pending;
   logic [15:0]      r_disp;
   logic             r_pend;
   logic [3:0]       r_nibble;
   logic [3:0]       r_digit_sel;
   logic             r_frame_done;

   logic             w_div_wrap;
   logic [DIV_W-1:0] w_div_nxt;
   logic [1:0]       w_idx_nxt;
   logic             w_boundary;
   logic [15:0]      w_disp_nxt;
   logic [3:0]       w_nibble_nxt;
   logic             w_lit;
   logic             w_blank;
   logic [3:0]       w_sel_nxt;

   // Next slot position, frame boundary and the display value that applies to it
   always_comb begin
      w_div_wrap = (r_div == DIV_MAX);
      w_div_nxt  = w_div_wrap ? '0 : r_div + DIV_W'(1);
      w_idx_nxt  = w_div_wrap ? r_idx + 2'd1 : r_idx;
      w_boundary = w_div_wrap && (r_idx == 2'd3);
      w_disp_nxt = (w_boundary && r_pend) ? r_pending : r_disp;
      w_nibble_nxt = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
   end

   // Leading-zero blanking: digit k is dark when nibbles k..3 are all zero
`ifdef SEG_SCAN_BLANK_EN
   logic w_zero3;
   logic w_zero2;
   logic w_zero1;

   always_comb begin
      w_zero3 = (w_disp_nxt[15:12] == 4'h0);
      w_zero2 = w_zero3 && (w_disp_nxt[11:8] == 4'h0);
      w_zero1 = w_zero2 && (w_disp_nxt[7:4] == 4'h0);
      w_blank = 1'b0;
      case (w_idx_nxt)
         2'd1:    w_blank = w_zero1;
         2'd2:    w_blank = w_zero2;
         2'd3:    w_blank = w_zero3;
         default: w_blank = 1'b0;
      endcase
   end
`else
   always_comb begin
      w_blank = 1'b0;
   end
`endif

   // Active-low enable for the upcoming cycle: one digit low once the guard has elapsed
   always_comb begin
      w_lit     = (w_div_nxt >= GUARD_V);
      w_sel_nxt = 4'hF;
      if (w_lit && !w_blank) begin
         w_sel_nxt[w_idx_nxt] = 1'b0;
      end
   end

   // Scan counters, double buffer and registered outputs, all advancing on one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div        <= '0;
         r_idx        <= 2'd0;
         r_pending    <= 16'h0000;
         r_disp       <= 16'h0000;
         r_pend       <= 1'b0;
         r_nibble     <= 4'h0;
         r_digit_sel  <= 4'hF;
         r_frame_done <= 1'b0;
      end else begin
         r_div        <= w_div_nxt;
         r_idx        <= w_idx_nxt;
         r_disp       <= w_disp_nxt;
         r_nibble     <= w_nibble_nxt;
         r_digit_sel  <= w_sel_nxt;
         r_frame_done <= w_boundary;
         // A load always wins over the boundary clear, so a coincident load stays pending
         if (load) begin
            r_pending <= value;
            r_pend    <= 1'b1;
         end else if (w_boundary) begin
            r_pend    <= 1'b0;
         end
      end
   end

   assign nibble     = r_nibble;
   assign digit_sel  = r_digit_sel;
   assign frame_done = r_frame_done;
   assign pend       = r_pend;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan with SCAN_DIV=8, GUARD=2.
// Stimulus queues one expected record per digit slot; a negedge monitor checks them.
module tb_seg_scan;

   localparam int unsigned SD = 8;
   localparam int unsigned GD = 2;

`ifdef SEG_SCAN_BLANK_EN
   localparam logic [3:0] LIT_0000 = 4'b0001;
   localparam logic [3:0] LIT_0050 = 4'b0011;
`else
   localparam logic [3:0] LIT_0000 = 4'b1111;
   localparam logic [3:0] LIT_0050 = 4'b1111;
`endif

   typedef struct {
      logic [3:0] nib;
      logic [3:0] sel;
      logic       pend;
   } slot_t;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  nibble;
   logic [3:0]  digit_sel;
   logic        frame_done;
   logic        pend;

   int    total = 0;
   int    bad   = 0;
   int    k;
   bit    mon_en = 1'b1;
   bit    have_cur = 1'b0;
   slot_t cur;
   slot_t exp_q[$];

   seg_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .value      (value),
      .nibble     (nibble),
      .digit_sel  (digit_sel),
      .frame_done (frame_done),
      .pend       (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles since reset release; state at count k has div=k%8, idx=(k/8)%4
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   task automatic chk(input string name, input int kk, input logic [15:0] act, input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s k=%0d got=%h want=%h", name, kk, act, want);
      end
   endtask

   // Queue four slot records: nibble from v, lit digits from lit, pend at slot end from pm
   task automatic push_frame(input logic [15:0] v, input logic [3:0] lit, input logic [3:0] pm);
      for (int i = 0; i < 4; i++) begin
         slot_t s;
         s.nib  = v[4*i +: 4];
         s.sel  = 4'hF;
         if (lit[i]) s.sel[i] = 1'b0;
         s.pend = pm[i];
         exp_q.push_back(s);
      end
   endtask

   task automatic step_to(input int kk);
      while (k < kk) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present value so that it is captured by the edge that produces count kk
   task automatic load_at(input int kk, input logic [15:0] v);
      step_to(kk - 1);
      load  = 1'b1;
      value = v;
      @(posedge clk);
      #1;
      load  = 1'b0;
   endtask

   // Monitor: pops one record per slot and checks every cycle of it
   always @(negedge clk) begin
      if (!rst_n) begin
         have_cur = 1'b0;
      end else if (mon_en) begin
         if ((k % SD) == 0) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               have_cur = 1'b0;
               $display("FAIL scoreboard_underflow k=%0d got=empty want=record", k);
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1'b1;
            end
         end
         if (have_cur) begin
            chk("nibble", k, 16'(nibble), 16'(cur.nib));
            chk("digit_sel", k, 16'(digit_sel), ((k % SD) < GD) ? 16'h000F : 16'(cur.sel));
            if ((k % SD) == SD - 1) chk("pend_slot_end", k, 16'(pend), 16'(cur.pend));
         end
         chk("frame_done", k, 16'(frame_done), 16'(((k % (4*SD)) == 0) && (k > 0)));
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog k=%0d got=timeout want=finish", k);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      value = 16'h0000;
      push_frame(16'h0000, LIT_0000, 4'b1111);
      push_frame(16'h1234, 4'b1111, 4'b0010);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      load_at(3, 16'h1234);
      load_at(42, 16'hFFFF);
      step_to(45);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_nibble", k, 16'(nibble), 16'h0000);
      chk("rst_digit_sel", k, 16'(digit_sel), 16'h000F);
      chk("rst_pend", k, 16'(pend), 16'h0000);
      chk("rst_frame_done", k, 16'(frame_done), 16'h0000);
      exp_q.delete();

      push_frame(16'h0000, LIT_0000, 4'b1100);
      push_frame(16'h1234, 4'b1111, 4'b1110);
      push_frame(16'hABCD, 4'b1111, 4'b1111);
      push_frame(16'h2222, 4'b1111, 4'b1111);
      push_frame(16'h5555, 4'b1111, 4'b1100);
      push_frame(16'h0050, LIT_0050, 4'b1110);
      push_frame(16'h0000, LIT_0000, 4'b0000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      load_at(20, 16'h1234);
      load_at(44, 16'hABCD);
      load_at(70, 16'h1111);
      load_at(80, 16'h2222);
      load_at(96, 16'h5555);
      load_at(150, 16'h0050);
      load_at(170, 16'h0000);
      step_to(223);
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("queue_drained", k, 16'(exp_q.size()), 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
# seg_scan

Four-digit time-multiplexed scanner that sits directly upstream of the single-digit 7-segment decoder. It holds a 16-bit hexadecimal display value and presents one nibble at a time to the decoder's `a,b,c,d` inputs. It drives the matching active-low digit-enable line and inserts an all-off guard interval between digits to suppress ghosting. New values are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot; legal range is ≥ 2.
- `GUARD`, 2000: all-off cycles at the start of each slot; legal range is 0 ≤ GUARD < SCAN_DIV.

- `clk`  in  1: single system clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: when high, `value` is captured into the pending register at this clock edge.
- `value`  in  16: display value; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `nibble`  out  4: nibble for the current digit; `nibble[3]` drives decoder `a`, `nibble[0]` drives `d`.
- `digit_sel`  out  4: active-low digit enables, one-hot-low or all-high.
- `frame_done`  out  1: one-cycle pulse on the first cycle of each new frame (idx 0).
- `pend`  out  1: a loaded value is waiting for the next frame boundary.

## Operation
- Divider `div` counts from 0 to SCAN_DIV-1 and wraps. When it wraps, slot index `idx` advances 0→1→2→3→0.
- Registers:
  - `pending[15:0]` with `pend`.
  - `disp[15:0]`, which is the only source for `nibble`.
- On `load=1`, `pending` takes `value` and `pend` is set. A load while `pend` is already 1 overwrites `pending`; the latest load wins, with no error.
- Frame boundary is the edge at which `idx` goes 3→0. If `pend` is 1, then `disp` takes `pending` and `pend` clears.
- Simultaneous `load` and frame boundary:
  - The old `pending` goes to `disp`.
  - The new `value` goes to `pending`.
  - `pend` stays 1.
- `nibble` = `disp[4*idx+3 : 4*idx]` for the whole slot, including the guard cycles.
- `digit_sel[idx]` = 0 only while `div ≥ GUARD`. All other bits are 1. With GUARD=0 the digit is on for the entire slot.
- `frame_done` = 1 exactly during the cycle with `idx=0` and `div=0`, after the first wrap from reset. It is not asserted on the post-reset cycle.
- The segment outputs of the decoder stage are not touched here. This block drives digit selection only.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - `div`=0, `idx`=0.
  - `disp`=0, `pending`=0, `pend`=0.
  - `nibble`=0, `digit_sel`=4'b1111, `frame_done`=0.
- Reset asserted mid-frame forces the reset values immediately. A pending value is lost.
- All outputs are registered. `nibble`, `digit_sel` and `frame_done` update on the same edge that updates `div`/`idx`. There is no extra pipeline stage.
- `load` → `pend`=1: visible on the cycle after the capturing edge.
- `load` → visible on `nibble`: at the next 3→0 boundary. Worst-case latency is 4·SCAN_DIV cycles.
- Frame period is 4·SCAN_DIV cycles. Each digit is lit for SCAN_DIV−GUARD cycles per frame.
- `digit_sel` never has two bits low in the same cycle.

## Configuration
- `SEG_SCAN_BLANK_EN` defined: leading-zero blanking.
  - Digit k (k = 1..3) is blanked when `disp` nibbles k through 3 are all 0. Blanking holds its `digit_sel` bit at 1 for the whole slot.
  - Digit 0 is never blanked.
  - `nibble`, `idx` and `frame_done` timing are unchanged.
- Not defined: every digit is enabled per the guard rule regardless of value.

## Test plan
Benches use SCAN_DIV=8 and GUARD=2.

- Reset behaviour: assert `rst_n`=0 mid-slot.
  - Required: `digit_sel`=1111, `nibble`=0, `pend`=0 with no clock edge.
  - Required after release: the first `frame_done` arrives 32 cycles later.
- Scan order: load 16'h1234 and wait one boundary.
  - Required per slot: `nibble` sequence 4,3,2,1 with `digit_sel` 1110, 1101, 1011, 0111.
  - Required per slot: 2 cycles of 1111 then 6 cycles enabled.
- Double buffering: load 16'hABCD while `disp`=16'h1234 and `idx`=1.
  - Required: `pend`=1, and the current frame still shows 3,2 in slots 2 and 3.
  - Required: the next frame shows D,C,B,A, and `pend` clears at the boundary.
- Overwrite and coincidence:
  - Load 16'h1111 then 16'h2222 before the boundary. Required: 2222 is displayed.
  - Load 16'h5555 on the boundary edge. Required: 2222 is displayed and `pend` stays 1; 5555 appears one frame later.
- Blanking with `SEG_SCAN_BLANK_EN` defined:
  - Load 16'h0050. Required: digits 2 and 3 have `digit_sel` held high; digits 0 and 1 are lit.
  - Load 16'h0000. Required: only digit 0 is lit.
  - Without the macro, all four digits are lit.
